// File: rtl/fall_step_ctrl.sv
// Motion stepper for one falling object: drives delay_unit and advances one pixel per expired interval.
// Define FALL_STEP_BOUNCE_EN to reverse direction at the side walls (default: clamp at the wall).
module fall_step_ctrl #(
    parameter int unsigned X_BITS     = 10,
    parameter int unsigned Y_BITS     = 10,
    parameter int unsigned DELAY_BITS = 8,
    parameter int          X_MIN      = 0,
    parameter int          X_MAX      = 639,
    parameter int unsigned Y_MAX      = 479,
    parameter int unsigned INIT_DELAY = 20,
    parameter int unsigned MIN_DELAY  = 4,
    parameter int unsigned RAMP_STEPS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [X_BITS-1:0]     init_x,
    input  logic                  init_dir,
    input  logic                  waiting,
    output logic                  delay_enable,
    output logic                  delay_rst,
    output logic [DELAY_BITS-1:0] delay,
    output logic [X_BITS-1:0]     pos_x,
    output logic [Y_BITS-1:0]     pos_y,
    output logic                  dir,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    localparam int unsigned           RAMP_BITS = $clog2(RAMP_STEPS + 1);
    localparam logic [X_BITS-1:0]     X_LO      = X_BITS'(X_MIN);
    localparam logic [X_BITS-1:0]     X_HI      = X_BITS'(X_MAX);
    localparam logic [Y_BITS-1:0]     Y_LAST    = Y_BITS'(Y_MAX - 1);
    localparam logic [DELAY_BITS-1:0] D_INIT    = DELAY_BITS'(INIT_DELAY);
    localparam logic [DELAY_BITS-1:0] D_MIN     = DELAY_BITS'(MIN_DELAY);
    localparam logic [RAMP_BITS-1:0]  R_LAST    = RAMP_BITS'(RAMP_STEPS - 1);

    state_t                state, state_nx;
    logic [RAMP_BITS-1:0]  ramp_cnt, ramp_nx;
    logic [X_BITS-1:0]     pos_x_nx, x_clamped;
    logic [Y_BITS-1:0]     pos_y_nx;
    logic [DELAY_BITS-1:0] delay_nx;
    logic                  dir_nx, busy_nx, done_nx, delay_enable_nx, delay_rst_nx;

    always_comb begin
        x_clamped = init_x;
        if (int'(init_x) > X_MAX)
            x_clamped = X_HI;
        else if (int'(init_x) < X_MIN)
            x_clamped = X_LO;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            pos_x        <= X_LO;
            pos_y        <= '0;
            dir          <= 1'b0;
            delay        <= D_INIT;
            ramp_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            delay_enable <= 1'b0;
            delay_rst    <= 1'b0;
        end else begin
            state        <= state_nx;
            pos_x        <= pos_x_nx;
            pos_y        <= pos_y_nx;
            dir          <= dir_nx;
            delay        <= delay_nx;
            ramp_cnt     <= ramp_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            delay_enable <= delay_enable_nx;
            delay_rst    <= delay_rst_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        pos_x_nx        = pos_x;
        pos_y_nx        = pos_y;
        dir_nx          = dir;
        delay_nx        = delay;
        ramp_nx         = ramp_cnt;
        busy_nx         = 1'b0;
        done_nx         = 1'b0;
        delay_enable_nx = 1'b0;
        delay_rst_nx    = 1'b0;
        case (state)
            // Launch values are registered on entry to LOAD so they are already
            // presented to delay_unit while its restart is asserted.
            S_IDLE: begin
                if (start) begin
                    state_nx     = S_LOAD;
                    pos_x_nx     = x_clamped;
                    pos_y_nx     = '0;
                    dir_nx       = init_dir;
                    delay_nx     = D_INIT;
                    ramp_nx      = '0;
                    busy_nx      = 1'b1;
                    delay_rst_nx = 1'b1;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx        = S_RUN;
                    busy_nx         = 1'b1;
                    delay_enable_nx = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else begin
                    busy_nx         = 1'b1;
                    delay_enable_nx = 1'b1;
                    if (!waiting) begin
                        pos_y_nx = pos_y + 1'b1;
                        if (dir) begin
                            if (pos_x == X_HI) begin
`ifdef FALL_STEP_BOUNCE_EN
                                pos_x_nx = X_HI - 1'b1;
                                dir_nx   = 1'b0;
`endif
                            end else begin
                                pos_x_nx = pos_x + 1'b1;
                            end
                        end else begin
                            if (pos_x == X_LO) begin
`ifdef FALL_STEP_BOUNCE_EN
                                pos_x_nx = X_LO + 1'b1;
                                dir_nx   = 1'b1;
`endif
                            end else begin
                                pos_x_nx = pos_x - 1'b1;
                            end
                        end
                        if (ramp_cnt == R_LAST) begin
                            ramp_nx = '0;
                            if (delay > D_MIN)
                                delay_nx = delay - 1'b1;
                        end else begin
                            ramp_nx = ramp_cnt + 1'b1;
                        end
                        if (pos_y == Y_LAST) begin
                            state_nx        = S_DONE;
                            busy_nx         = 1'b0;
                            delay_enable_nx = 1'b0;
                            done_nx         = 1'b1;
                        end
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fall_step_ctrl.sv
// Self-checking bench for fall_step_ctrl against a closed-form motion/ramp model.
module tb_fall_step_ctrl;

    localparam int X_BITS     = 10;
    localparam int Y_BITS     = 10;
    localparam int DELAY_BITS = 8;
    localparam int X_MIN      = 2;
    localparam int X_MAX      = 639;
    localparam int INIT_DELAY = 20;
    localparam int MIN_DELAY  = 4;
    localparam int RAMP_STEPS = 16;
    localparam int Y_MAX_A    = 479;
    localparam int Y_MAX_B    = 8;
    localparam int VW         = X_BITS + Y_BITS + 1 + DELAY_BITS + 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, abort_a = 1'b0, waiting_a = 1'b1;
    logic start_b = 1'b0, abort_b = 1'b0, waiting_b = 1'b1;
    logic [X_BITS-1:0] init_x = '0;
    logic init_dir = 1'b0;

    logic                  en_a, rst_a, dir_a, busy_a, done_a;
    logic [DELAY_BITS-1:0] delay_a;
    logic [X_BITS-1:0]     pos_x_a;
    logic [Y_BITS-1:0]     pos_y_a;
    logic                  en_b, rst_b, dir_b, busy_b, done_b;
    logic [DELAY_BITS-1:0] delay_b;
    logic [X_BITS-1:0]     pos_x_b;
    logic [Y_BITS-1:0]     pos_y_b;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_x, m_y, m_steps;
    bit m_dir;

    always #5 clk = ~clk;

    fall_step_ctrl #(
        .X_BITS(X_BITS), .Y_BITS(Y_BITS), .DELAY_BITS(DELAY_BITS),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MAX(Y_MAX_A),
        .INIT_DELAY(INIT_DELAY), .MIN_DELAY(MIN_DELAY), .RAMP_STEPS(RAMP_STEPS)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .init_x(init_x), .init_dir(init_dir), .waiting(waiting_a),
        .delay_enable(en_a), .delay_rst(rst_a), .delay(delay_a),
        .pos_x(pos_x_a), .pos_y(pos_y_a), .dir(dir_a), .busy(busy_a), .done(done_a)
    );

    fall_step_ctrl #(
        .X_BITS(X_BITS), .Y_BITS(Y_BITS), .DELAY_BITS(DELAY_BITS),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MAX(Y_MAX_B),
        .INIT_DELAY(INIT_DELAY), .MIN_DELAY(MIN_DELAY), .RAMP_STEPS(RAMP_STEPS)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .init_x(init_x), .init_dir(init_dir), .waiting(waiting_b),
        .delay_enable(en_b), .delay_rst(rst_b), .delay(delay_b),
        .pos_x(pos_x_b), .pos_y(pos_y_b), .dir(dir_b), .busy(busy_b), .done(done_b)
    );

    function automatic int clamp_x(input int v);
        if (v > X_MAX) return X_MAX;
        if (v < X_MIN) return X_MIN;
        return v;
    endfunction

    function automatic int exp_delay();
        int d;
        d = INIT_DELAY - m_steps / RAMP_STEPS;
        return (d < MIN_DELAY) ? MIN_DELAY : d;
    endfunction

    function automatic void model_reset();
        m_x = X_MIN; m_y = 0; m_dir = 1'b0; m_steps = 0;
    endfunction

    function automatic void model_step();
        m_y++;
        m_steps++;
        if (m_dir) begin
            if (m_x == X_MAX) begin
`ifdef FALL_STEP_BOUNCE_EN
                m_x = X_MAX - 1; m_dir = 1'b0;
`endif
            end else m_x++;
        end else begin
            if (m_x == X_MIN) begin
`ifdef FALL_STEP_BOUNCE_EN
                m_x = X_MIN + 1; m_dir = 1'b1;
`endif
            end else m_x--;
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec(input bit b, input bit d, input bit e, input bit r);
        return {X_BITS'(m_x), Y_BITS'(m_y), m_dir, DELAY_BITS'(exp_delay()), b, d, e, r};
    endfunction

    function automatic logic [VW-1:0] vec(input bit sel);
        if (sel) return {pos_x_b, pos_y_b, dir_b, delay_b, busy_b, done_b, en_b, rst_b};
        return {pos_x_a, pos_y_a, dir_a, delay_a, busy_a, done_a, en_a, rst_a};
    endfunction

    task automatic launch(input bit sel, input int x, input bit d);
        logic [VW-1:0] got, exp;
        init_x = X_BITS'(x);
        init_dir = d;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        m_x = clamp_x(int'(init_x)); m_y = 0; m_dir = d; m_steps = 0;
        got = vec(sel); exp = exp_vec(1, 0, 0, 1);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL load_state: got %h expected %h", got, exp); end
        @(negedge clk);
        got = vec(sel); exp = exp_vec(1, 0, 1, 0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL run_entry: got %h expected %h", got, exp); end
    endtask

    task automatic step(input bit sel);
        if (sel) waiting_b = 1'b0; else waiting_a = 1'b0;
        @(negedge clk);
        waiting_a = 1'b1; waiting_b = 1'b1;
        model_step();
    endtask

    task automatic abort_cycle(input bit sel);
        if (sel) abort_b = 1'b1; else abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0; abort_b = 1'b0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] got, exp;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        exp = exp_vec(0, 0, 0, 0);
        got = vec(0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_a: got %h expected %h", got, exp); end
        got = vec(1);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_b: got %h expected %h", got, exp); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [VW-1:0] got, exp;
        launch(0, 100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(0);
            got = vec(0); exp = exp_vec(1, 0, 1, 0);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_step%0d: got %h expected %h", i, got, exp); end
        end
        checks++;
        if ({pos_x_a, pos_y_a, busy_a, delay_a} !== {10'd103, 10'd3, 1'b1, 8'd20}) begin
            errors++;
            $display("FAIL basic_final: got x=%0d y=%0d busy=%b delay=%0d expected x=103 y=3 busy=1 delay=20",
                     pos_x_a, pos_y_a, busy_a, delay_a);
        end
        // start while running must be ignored
        init_x = 10'd400;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        got = vec(0); exp = exp_vec(1, 0, 1, 0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL start_in_run: got %h expected %h", got, exp); end
        abort_cycle(0);
    endtask

    task automatic test_edges();
        bit ex_dir;
        int ex_x;
        launch(0, 638, 1'b1);
        step(0);
        step(0);
`ifdef FALL_STEP_BOUNCE_EN
        ex_x = 638; ex_dir = 1'b0;
`else
        ex_x = 639; ex_dir = 1'b1;
`endif
        checks++;
        if (pos_x_a !== X_BITS'(ex_x) || dir_a !== ex_dir || pos_x_a !== X_BITS'(m_x)) begin
            errors++;
            $display("FAIL right_edge: got x=%0d dir=%b expected x=%0d dir=%b", pos_x_a, dir_a, ex_x, ex_dir);
        end
        abort_cycle(0);
        launch(0, 3, 1'b0);
        step(0);
        step(0);
`ifdef FALL_STEP_BOUNCE_EN
        ex_x = 3; ex_dir = 1'b1;
`else
        ex_x = 2; ex_dir = 1'b0;
`endif
        checks++;
        if (pos_x_a !== X_BITS'(ex_x) || dir_a !== ex_dir || pos_x_a !== X_BITS'(m_x)) begin
            errors++;
            $display("FAIL left_edge: got x=%0d dir=%b expected x=%0d dir=%b", pos_x_a, dir_a, ex_x, ex_dir);
        end
        abort_cycle(0);
    endtask

    task automatic test_clamp();
        launch(0, 5000, 1'b0);
        checks++;
        if (pos_x_a !== 10'd639) begin errors++; $display("FAIL clamp_high: got %0d expected 639", pos_x_a); end
        abort_cycle(0);
        launch(0, 1, 1'b1);
        checks++;
        if (pos_x_a !== 10'd2) begin errors++; $display("FAIL clamp_low: got %0d expected 2", pos_x_a); end
        abort_cycle(0);
    endtask

    task automatic test_ramp_random();
        logic [VW-1:0] got, exp;
        bit stepped;
        int cycles;
        launch(0, int'($urandom_range(X_MAX, X_MIN)), 1'($urandom_range(1, 0)));
        cycles = 0;
        while (m_steps < 276 && cycles < 3000) begin
            stepped = ($urandom_range(2, 0) == 0);
            waiting_a = ~stepped;
            @(negedge clk);
            waiting_a = 1'b1;
            if (stepped) model_step();
            got = vec(0); exp = exp_vec(1, 0, 1, 0);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL ramp_cycle%0d: got %h expected %h", cycles, got, exp); end
            if (stepped && m_steps == 16) begin
                checks++;
                if (delay_a !== 8'd19) begin errors++; $display("FAIL ramp_16: got %0d expected 19", delay_a); end
            end
            if (stepped && m_steps == 256) begin
                checks++;
                if (delay_a !== 8'd4) begin errors++; $display("FAIL ramp_256: got %0d expected 4", delay_a); end
            end
            cycles++;
        end
        checks++;
        if (m_steps < 276 || delay_a !== 8'd4) begin
            errors++;
            $display("FAIL ramp_floor: got steps=%0d delay=%0d expected steps=276 delay=4", m_steps, delay_a);
        end
        abort_cycle(0);
    endtask

    task automatic test_abort();
        logic [VW-1:0] got, exp;
        launch(0, 200, 1'b0);
        step(0);
        step(0);
        waiting_a = 1'b0;
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        got = vec(0); exp = exp_vec(0, 0, 0, 0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL abort_with_step: got %h expected %h", got, exp); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = vec(0);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL idle_hold%0d: got %h expected %h", i, got, exp); end
        end
        waiting_a = 1'b1;
        init_x = 10'd50;
        init_dir = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b1;
        m_x = 50; m_y = 0; m_dir = 1'b1; m_steps = 0;
        @(negedge clk);
        abort_a = 1'b0;
        got = vec(0); exp = exp_vec(0, 0, 0, 0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL abort_in_load: got %h expected %h", got, exp); end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] got, exp;
        launch(0, 50, 1'b1);
        step(0);
        step(0);
        step(0);
        reset = 1'b1;
        waiting_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        waiting_a = 1'b1;
        model_reset();
        got = vec(0); exp = exp_vec(0, 0, 0, 0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_mid_run: got %h expected %h", got, exp); end
        @(negedge clk);
        got = vec(0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_then_idle: got %h expected %h", got, exp); end
    endtask

    task automatic test_landing();
        logic [VW-1:0] got, exp;
        launch(1, 300, 1'b1);
        for (int i = 1; i <= Y_MAX_B; i++) begin
            step(1);
            got = vec(1);
            exp = (m_y == Y_MAX_B) ? exp_vec(0, 1, 0, 0) : exp_vec(1, 0, 1, 0);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL land_step%0d: got %h expected %h", i, got, exp); end
        end
        checks++;
        if (pos_y_b !== 10'd8 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL land_row: got y=%0d done=%b expected y=8 done=1", pos_y_b, done_b);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = vec(1); exp = exp_vec(0, 0, 0, 0);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL done_pulse%0d: got %h expected %h", i, got, exp); end
        end
        launch(1, 10, 1'b0);
        step(1);
        got = vec(1); exp = exp_vec(1, 0, 1, 0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL relaunch: got %h expected %h", got, exp); end
        checks++;
        if (done_a !== 1'b0) begin errors++; $display("FAIL no_done_a: got %b expected 0", done_a); end
        abort_cycle(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_clamp();
        test_ramp_random();
        test_abort();
        test_reset_mid();
        test_landing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
